// File: rtl/mod_cache_wb_pkg.sv
// Shared types and address-field helpers for the write-back direct-mapped cache.
// The field helpers take the geometry as arguments so any INDEX_BITS/OFFSET_BITS works.
package mod_cache_wb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWb    = 2'd1,
        StFill  = 2'd2,
        StFlush = 2'd3
    } state_e;

    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int unsigned offset_bits);
        return (addr >> 2) & ((32'd1 << offset_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned index_bits,
                                               input int unsigned offset_bits);
        return (addr >> (offset_bits + 2)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned index_bits,
                                             input int unsigned offset_bits);
        return addr >> (index_bits + offset_bits + 2);
    endfunction

endpackage

// File: rtl/mod_cache_wb_if.sv
// Word-wide memory-side request/ack bus between the cache (master) and mod_sram (slave).
interface mod_cache_wb_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cache_line_store.sv
// Line storage: async-read data array with one write port, tag array, and
// resettable valid/dirty flops addressed by a single line index.
module cache_line_store #(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2,
    parameter int unsigned TAG_BITS    = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  i_idx,
    input  logic [OFFSET_BITS-1:0] i_rd_off,
    output logic [31:0]            o_rd_data,
    output logic [TAG_BITS-1:0]    o_tag,
    output logic                   o_valid,
    output logic                   o_dirty,
    input  logic                   i_wr_en,
    input  logic [OFFSET_BITS-1:0] i_wr_off,
    input  logic [31:0]            i_wr_data,
    input  logic                   i_line_fill,
    input  logic [TAG_BITS-1:0]    i_tag,
    input  logic                   i_dirty_set,
    input  logic                   i_dirty_clr
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned WORDS = 1 << (INDEX_BITS + OFFSET_BITS);

    logic [31:0]         r_data [WORDS];
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;

    always_ff @(posedge clk) begin
        if (i_wr_en)     r_data[{i_idx, i_wr_off}] <= i_wr_data;
        if (i_line_fill) r_tag[i_idx] <= i_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_line_fill) begin
                r_valid[i_idx] <= 1'b1;
                r_dirty[i_idx] <= 1'b0;
            end
            if (i_dirty_clr) r_dirty[i_idx] <= 1'b0;
            if (i_dirty_set) r_dirty[i_idx] <= 1'b1;
        end
    end

    assign o_rd_data = r_data[{i_idx, i_rd_off}];
    assign o_tag     = r_tag[i_idx];
    assign o_valid   = r_valid[i_idx];
    assign o_dirty   = r_dirty[i_idx];
endmodule

// File: rtl/mod_cache_wb.sv
// Direct-mapped, write-allocate, write-back cache controller with multi-word lines,
// per-line dirty bits and a flush walk over all lines.
module mod_cache_wb
    import mod_cache_wb_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_cpu_req,
    input  logic         i_cpu_we,
    input  logic [31:0]  i_cpu_addr,
    input  logic [31:0]  i_cpu_din,
    output logic [31:0]  o_cpu_dout,
    output logic         o_cpu_stall,
    input  logic         i_flush,
    output logic         o_flush_busy,
    mod_cache_wb_if.master mem
);
    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;

    state_e                 r_state, w_state_nxt;
    logic [OFFSET_BITS-1:0] r_cnt, w_cnt_nxt;
    logic [INDEX_BITS-1:0]  r_ptr, w_ptr_nxt;
    logic                   r_mem_req, w_mem_req_nxt;
    logic                   r_mem_we, w_mem_we_nxt;
    logic [31:0]            r_mem_addr, w_mem_addr_nxt;
    logic [31:0]            r_mem_wdata, w_mem_wdata_nxt;
    logic                   r_flush_busy, w_flush_busy_nxt;

    logic [OFFSET_BITS-1:0] w_cpu_off, w_rd_off, w_wr_off;
    logic [INDEX_BITS-1:0]  w_cpu_idx, w_line_idx;
    logic [TAG_BITS-1:0]    w_cpu_tag, w_line_tag, w_addr_tag;
    logic [31:0]            w_rd_data, w_wr_data, w_cur_addr;
    logic                   w_valid, w_dirty, w_hit, w_last_word, w_last_line;
    logic                   w_wr_en, w_line_fill, w_dirty_set, w_dirty_clr;
    logic                   w_unused_addr;

    assign w_cpu_off     = OFFSET_BITS'(addr_offset(i_cpu_addr, OFFSET_BITS));
    assign w_cpu_idx     = INDEX_BITS'(addr_index(i_cpu_addr, INDEX_BITS, OFFSET_BITS));
    assign w_cpu_tag     = TAG_BITS'(addr_tag(i_cpu_addr, INDEX_BITS, OFFSET_BITS));
    assign w_unused_addr = ^i_cpu_addr[1:0];

    // The flush walk owns the line index; every other state works on the CPU's line.
    assign w_line_idx  = (r_state == StFlush) ? r_ptr : w_cpu_idx;
    assign w_rd_off    = (r_state == StIdle) ? w_cpu_off : r_cnt;
    assign w_hit       = w_valid && (w_line_tag == w_cpu_tag);
    assign w_last_word = (r_cnt == '1);
    assign w_last_line = (r_ptr == '1);
    assign w_addr_tag  = (r_state == StFill) ? w_cpu_tag : w_line_tag;
    assign w_cur_addr  = {w_addr_tag, w_line_idx, r_cnt, 2'b00};

    cache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_idx      (w_line_idx),
        .i_rd_off   (w_rd_off),
        .o_rd_data  (w_rd_data),
        .o_tag      (w_line_tag),
        .o_valid    (w_valid),
        .o_dirty    (w_dirty),
        .i_wr_en    (w_wr_en),
        .i_wr_off   (w_wr_off),
        .i_wr_data  (w_wr_data),
        .i_line_fill(w_line_fill),
        .i_tag      (w_cpu_tag),
        .i_dirty_set(w_dirty_set),
        .i_dirty_clr(w_dirty_clr)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ptr_nxt        = r_ptr;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_flush_busy_nxt = r_flush_busy;
        w_wr_en          = 1'b0;
        w_wr_off         = r_cnt;
        w_wr_data        = mem.mem_rdata;
        w_line_fill      = 1'b0;
        w_dirty_set      = 1'b0;
        w_dirty_clr      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_flush) begin
                    w_state_nxt      = StFlush;
                    w_flush_busy_nxt = 1'b1;
                    w_ptr_nxt        = '0;
                    w_cnt_nxt        = '0;
                end else if (i_cpu_req) begin
                    if (w_hit) begin
                        if (i_cpu_we) begin
                            w_wr_en     = 1'b1;
                            w_wr_off    = w_cpu_off;
                            w_wr_data   = i_cpu_din;
                            w_dirty_set = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_valid && w_dirty) ? StWb : StFill;
                    end
                end
            end
            StWb, StFlush: begin
                // Flush reuses the write-back handshake; clean lines cost one cycle.
                if (!r_mem_req) begin
                    if (r_state == StWb || (w_valid && w_dirty)) begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = 1'b1;
                        w_mem_addr_nxt  = w_cur_addr;
                        w_mem_wdata_nxt = w_rd_data;
                    end else begin
                        w_ptr_nxt = r_ptr + INDEX_BITS'(1);
                        if (w_last_line) begin
                            w_state_nxt      = StIdle;
                            w_flush_busy_nxt = 1'b0;
                        end
                    end
                end else if (mem.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_cnt_nxt     = r_cnt + OFFSET_BITS'(1);
                    if (w_last_word) begin
                        w_dirty_clr = 1'b1;
                        if (r_state == StWb) w_state_nxt = StFill;
                    end
                end
            end
            StFill: begin
                if (!r_mem_req) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = w_cur_addr;
                end else if (mem.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_wr_en       = 1'b1;
                    w_cnt_nxt     = r_cnt + OFFSET_BITS'(1);
                    if (w_last_word) begin
                        w_line_fill = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_flush_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_flush_busy <= w_flush_busy_nxt;
        end
    end

    // A flush arriving with a request wins, so the request must stall that cycle.
    assign o_cpu_stall   = rst || (r_state != StIdle) || (i_cpu_req && (!w_hit || i_flush));
    assign o_cpu_dout    = w_rd_data;
    assign o_flush_busy  = r_flush_busy;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mod_cache_wb.sv
// Scoreboard bench for mod_cache_wb: a 2-cycle-latency memory model, expected CPU reads
// and memory words queued by the stimulus, and a negedge monitor that pops and compares.
module tb_mod_cache_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        cpu_stall, flush_busy;

    mod_cache_wb_if bus();

    mod_cache_wb #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_din   (cpu_din),
        .o_cpu_dout  (cpu_dout),
        .o_cpu_stall (cpu_stall),
        .i_flush     (flush),
        .o_flush_busy(flush_busy),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_cpu[$];
    logic [31:0] mem_store [logic [31:0]];
    int          tests = 0, fails = 0, n_acks = 0, lat = 0;
    logic        spur = 1'b0;
    mem_exp_t    mon_e;
    logic [31:0] mon_d;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {16'hCAFE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ack two cycles after the request is seen, one-cycle pulse.
    initial bus.mem_ack = 1'b0;
    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        #2;
        if (rst) begin
            bus.mem_ack = 1'b0;
            lat = 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else if (spur) begin
            bus.mem_ack = 1'b1;
            spur = 1'b0;
        end else if (bus.mem_req) begin
            lat++;
            if (lat == 2) begin
                lat = 0;
                bus.mem_ack = 1'b1;
                if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = mem_rd(bus.mem_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.mem_req && bus.mem_ack) begin
            n_acks++;
            if (exp_mem.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mem_unexpected: got addr %h we %0b expected no transaction",
                         bus.mem_addr, bus.mem_we);
            end else begin
                mon_e = exp_mem.pop_front();
                check("mem_we", {31'd0, bus.mem_we}, {31'd0, mon_e.we});
                check("mem_addr", bus.mem_addr, mon_e.addr);
                if (mon_e.we) check("mem_wdata", bus.mem_wdata, mon_e.data);
            end
        end
        if (!rst && cpu_req && !cpu_stall && !cpu_we) begin
            if (exp_cpu.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL cpu_unexpected: got %h expected no read", cpu_dout);
            end else begin
                mon_d = exp_cpu.pop_front();
                check("cpu_dout", cpu_dout, mon_d);
            end
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] data);
        exp_mem.push_back('{we: we, addr: addr, data: data});
    endtask

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) push_mem(1'b0, base + 32'(4 * i), 32'd0);
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] din,
                              output int stalls);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            if (stalls > 300) begin
                tests++;
                fails++;
                $display("FAIL access_timeout: addr %h still stalled, expected completion", addr);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (flush_busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int st, n, base;
        #600000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int st, n, base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, cpu_stall}, 32'd1);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_no_stall", {31'd0, cpu_stall}, 32'd0);

        // 1: cold read fill, then 0-latency hit
        push_fill(32'h100);
        exp_cpu.push_back(32'hCAFE0100);
        cpu_access(1'b0, 32'h100, 32'd0, st);
        check("t1_cold_stalls", st, 13);
        exp_cpu.push_back(32'hCAFE0104);
        cpu_access(1'b0, 32'h104, 32'd0, st);
        check("t1_hit_stalls", st, 0);
        check("t1_hit_no_req", {31'd0, bus.mem_req}, 32'd0);

        // 2: write hit, then conflicting read forces write-back + fill
        cpu_access(1'b1, 32'h104, 32'hDEADBEEF, st);
        check("t2_wr_hit_stalls", st, 0);
        push_mem(1'b1, 32'h100, 32'hCAFE0100);
        push_mem(1'b1, 32'h104, 32'hDEADBEEF);
        push_mem(1'b1, 32'h108, 32'hCAFE0108);
        push_mem(1'b1, 32'h10C, 32'hCAFE010C);
        push_fill(32'h500);
        exp_cpu.push_back(32'hCAFE0504);
        cpu_access(1'b0, 32'h504, 32'd0, st);
        check("t2_wb_fill_stalls", st, 25);

        // 3: write miss allocates, flush writes the dirty line back
        push_fill(32'h200);
        cpu_access(1'b1, 32'h208, 32'h12345678, st);
        check("t3_wr_miss_stalls", st, 13);
        exp_cpu.push_back(32'h12345678);
        cpu_access(1'b0, 32'h208, 32'd0, st);
        check("t3_rd_alloc_stalls", st, 0);
        push_mem(1'b1, 32'h200, 32'hCAFE0200);
        push_mem(1'b1, 32'h204, 32'hCAFE0204);
        push_mem(1'b1, 32'h208, 32'h12345678);
        push_mem(1'b1, 32'h20C, 32'hCAFE020C);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("t3_busy_rise", {31'd0, flush_busy}, 32'd1);
        wait_busy_low(n);
        check("t3_flush_len", n, 28);
        exp_cpu.push_back(32'h12345678);
        cpu_access(1'b0, 32'h208, 32'd0, st);
        check("t3_valid_kept", st, 0);

        // 4: flush beats a same-cycle request; flush during FILL is ignored
        push_fill(32'h300);
        exp_cpu.push_back(32'hCAFE0300);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300; flush = 1'b1;
        @(negedge clk);
        check("t4_flush_wins_stall", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk); #1 flush = 1'b0;
        check("t4_busy_rise", {31'd0, flush_busy}, 32'd1);
        wait_busy_low(n);
        check("t4_flush_len", n, 16);
        n = 0;
        while (!bus.mem_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("t4_flush_ignored", {31'd0, flush_busy}, 32'd0);
        n = 0;
        forever begin
            @(negedge clk);
            if (!cpu_stall || n > 100) break;
            n++;
        end
        check("t4_replay_done", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk); #1 cpu_req = 1'b0;

        // 5: reset during the second fill word
        push_mem(1'b0, 32'h040, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h040;
        base = n_acks;
        n = 0;
        while (!(n_acks > base && bus.mem_req) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("t5_stall_in_rst", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk); #1;
        check("t5_req_dropped", {31'd0, bus.mem_req}, 32'd0);
        cpu_req = 1'b0;
        rst = 1'b0;
        push_fill(32'h040);
        exp_cpu.push_back(32'hCAFE0040);
        cpu_access(1'b0, 32'h040, 32'd0, st);
        check("t5_refill_stalls", st, 13);
        push_fill(32'h300);
        exp_cpu.push_back(32'hCAFE0304);
        cpu_access(1'b0, 32'h304, 32'd0, st);
        check("t5_line0_invalid", st, 13);

        // 6: spurious ack in IDLE changes nothing
        @(posedge clk); #1 spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
        end
        check("t6_no_flush", {31'd0, flush_busy}, 32'd0);
        exp_cpu.push_back(32'hCAFE0040);
        cpu_access(1'b0, 32'h040, 32'd0, st);
        check("t6_hit_040", st, 0);
        exp_cpu.push_back(32'hCAFE0308);
        cpu_access(1'b0, 32'h308, 32'd0, st);
        check("t6_hit_308", st, 0);

        repeat (4) @(posedge clk);
        check("mem_queue_drained", exp_mem.size(), 32'd0);
        check("cpu_queue_drained", exp_cpu.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
